// File: rtl/clock_time_counter.sv
// Time-of-day register: BCD minutes/hours advanced by up60_i/up24_i, day_tick_o on midnight.
// Define TWELVE_HOUR_EN to build the 12h (AM/PM) variant; default is 24h with pm_o tied low.
module clock_time_counter #(
   parameter int RESET_HOUR = 0,
   parameter int RESET_MIN  = 0
) (
   input  logic       ck_i,
   input  logic       reset_i,
   input  logic       up60_i,
   input  logic       up24_i,
   output logic [2:0] min_tens_o,
   output logic [3:0] min_units_o,
   output logic [1:0] hour_tens_o,
   output logic [3:0] hour_units_o,
   output logic       pm_o,
   output logic       day_tick_o
);

   localparam int RH = (RESET_HOUR >= 0 && RESET_HOUR <= 23) ? RESET_HOUR : 0;
   localparam int RM = (RESET_MIN  >= 0 && RESET_MIN  <= 59) ? RESET_MIN  : 0;
`ifdef TWELVE_HOUR_EN
   localparam int   RH_DISP = (RH == 0) ? 12 : ((RH > 12) ? RH - 12 : RH);
   localparam logic RST_PM  = (RH >= 12);
`else
   localparam int   RH_DISP = RH;
`endif
   localparam logic [2:0] RST_MT = 3'(RM / 10);
   localparam logic [3:0] RST_MU = 4'(RM % 10);
   localparam logic [1:0] RST_HT = 2'(RH_DISP / 10);
   localparam logic [3:0] RST_HU = 4'(RH_DISP % 10);

   logic [2:0] min_tens_q, min_tens_d;
   logic [3:0] min_units_q, min_units_d;
   logic [1:0] hour_tens_q, hour_tens_d;
   logic [3:0] hour_units_q, hour_units_d;
   logic       day_tick_q, day_tick_d;
   logic       min_carry;
   logic       hour_inc;
`ifdef TWELVE_HOUR_EN
   logic       pm_q, pm_d;
`endif

   assign min_carry = up60_i && (min_tens_q == 3'd5) && (min_units_q == 4'd9);
   assign hour_inc  = min_carry | up24_i;

   always_comb begin
      min_tens_d   = min_tens_q;
      min_units_d  = min_units_q;
      hour_tens_d  = hour_tens_q;
      hour_units_d = hour_units_q;
      day_tick_d   = 1'b0;
`ifdef TWELVE_HOUR_EN
      pm_d         = pm_q;
`endif
      // Out-of-range digits snap to 0 without carrying.
      if (up60_i) begin
         if (min_units_q >= 4'd9) begin
            min_units_d = 4'd0;
            if (min_units_q == 4'd9)
               min_tens_d = (min_tens_q >= 3'd5) ? 3'd0 : min_tens_q + 3'd1;
         end else begin
            min_units_d = min_units_q + 4'd1;
         end
      end

      if (hour_inc) begin
`ifdef TWELVE_HOUR_EN
         if (hour_tens_q == 2'd1 && hour_units_q == 4'd2) begin
            hour_tens_d  = 2'd0;
            hour_units_d = 4'd1;
         end else if (hour_tens_q == 2'd1 && hour_units_q == 4'd1) begin
            // 11 -> 12 flips the half-day; leaving PM means midnight.
            hour_units_d = 4'd2;
            pm_d         = ~pm_q;
            day_tick_d   = pm_q;
         end else if (hour_units_q >= 4'd9) begin
            hour_units_d = 4'd0;
            if (hour_units_q == 4'd9)
               hour_tens_d = (hour_tens_q == 2'd0) ? 2'd1 : 2'd0;
         end else begin
            hour_units_d = hour_units_q + 4'd1;
         end
`else
         if (hour_tens_q == 2'd2 && hour_units_q == 4'd3) begin
            hour_tens_d  = 2'd0;
            hour_units_d = 4'd0;
            day_tick_d   = 1'b1;
         end else if (hour_units_q >= 4'd9) begin
            hour_units_d = 4'd0;
            if (hour_units_q == 4'd9)
               hour_tens_d = (hour_tens_q >= 2'd2) ? 2'd0 : hour_tens_q + 2'd1;
         end else begin
            hour_units_d = hour_units_q + 4'd1;
         end
`endif
      end
   end

   always_ff @(posedge ck_i or posedge reset_i) begin
      if (reset_i) begin
         min_tens_q   <= RST_MT;
         min_units_q  <= RST_MU;
         hour_tens_q  <= RST_HT;
         hour_units_q <= RST_HU;
         day_tick_q   <= 1'b0;
      end else begin
         min_tens_q   <= min_tens_d;
         min_units_q  <= min_units_d;
         hour_tens_q  <= hour_tens_d;
         hour_units_q <= hour_units_d;
         day_tick_q   <= day_tick_d;
      end
   end

`ifdef TWELVE_HOUR_EN
   always_ff @(posedge ck_i or posedge reset_i) begin
      if (reset_i) pm_q <= RST_PM;
      else         pm_q <= pm_d;
   end
   assign pm_o = pm_q;
`else
   assign pm_o = 1'b0;
`endif

   assign min_tens_o   = min_tens_q;
   assign min_units_o  = min_units_q;
   assign hour_tens_o  = hour_tens_q;
   assign hour_units_o = hour_units_q;
   assign day_tick_o   = day_tick_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter; times are compared as hex hhmm (0x1437 = 14:37).
module tb_clock_time_counter;

   logic       ck_i = 1'b0;
   logic       reset_i = 1'b1;
   logic       up60_i = 1'b0;
   logic       up24_i = 1'b0;
   logic [2:0] min_tens_o;
   logic [3:0] min_units_o;
   logic [1:0] hour_tens_o;
   logic [3:0] hour_units_o;
   logic       pm_o;
   logic       day_tick_o;
   logic [15:0] t_obs;

   int n_chk = 0;
   int n_err = 0;

   clock_time_counter #(.RESET_HOUR(0), .RESET_MIN(0)) dut (
      .ck_i(ck_i), .reset_i(reset_i), .up60_i(up60_i), .up24_i(up24_i),
      .min_tens_o(min_tens_o), .min_units_o(min_units_o),
      .hour_tens_o(hour_tens_o), .hour_units_o(hour_units_o),
      .pm_o(pm_o), .day_tick_o(day_tick_o)
   );

   always #5 ck_i = ~ck_i;

   assign t_obs = {2'b00, hour_tens_o, hour_units_o, 1'b0, min_tens_o, min_units_o};

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive inputs, take one rising edge, return 1 time unit after it.
   task automatic tick(input logic a60, input logic a24);
      up60_i = a60;
      up24_i = a24;
      @(posedge ck_i);
      #1;
   endtask

   task automatic do_reset();
      up60_i  = 1'b0;
      up24_i  = 1'b0;
      reset_i = 1'b1;
      #2;
      reset_i = 1'b0;
   endtask

   // Reset to 00:00 (12 AM in 12h mode) then advance by h hours and m minutes.
   task automatic set_time(input int h, input int m);
      do_reset();
      for (int i = 0; i < h; i++) tick(1'b0, 1'b1);
      for (int i = 0; i < m; i++) tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
   endtask

   initial begin
      #12;
      reset_i = 1'b0;
      tick(1'b0, 1'b0);
`ifndef TWELVE_HOUR_EN
      chk("reset_time", t_obs, 16'h0000);
      chk("reset_tick", {15'd0, day_tick_o}, 16'h0000);
      chk("reset_pm", {15'd0, pm_o}, 16'h0000);

      set_time(14, 37);
      chk("reach_1437", t_obs, 16'h1437);
      up60_i  = 1'b1;
      reset_i = 1'b1;
      #1;
      chk("async_reset", t_obs, 16'h0000);
      @(posedge ck_i);
      #1;
      chk("reset_holds", t_obs, 16'h0000);
      reset_i = 1'b0;
      up60_i  = 1'b0;

      set_time(0, 8);
      tick(1'b1, 1'b0);
      chk("min_0009", t_obs, 16'h0009);
      tick(1'b1, 1'b0);
      chk("min_units_carry", t_obs, 16'h0010);

      set_time(9, 59);
      tick(1'b1, 1'b0);
      chk("hour_0959", t_obs, 16'h1000);
      chk("no_tick_1000", {15'd0, day_tick_o}, 16'h0000);

      set_time(19, 59);
      tick(1'b1, 1'b0);
      chk("hour_tens_carry", t_obs, 16'h2000);

      set_time(23, 59);
      tick(1'b1, 1'b0);
      chk("midnight_up60", t_obs, 16'h0000);
      chk("day_tick_up60", {15'd0, day_tick_o}, 16'h0001);
      tick(1'b0, 1'b0);
      chk("day_tick_clear", {15'd0, day_tick_o}, 16'h0000);

      set_time(12, 59);
      tick(1'b1, 1'b1);
      chk("both_1259", t_obs, 16'h1300);

      set_time(12, 59);
      tick(1'b0, 1'b1);
      chk("up24_no_min", t_obs, 16'h1359);

      set_time(23, 59);
      tick(1'b1, 1'b1);
      chk("both_2359", t_obs, 16'h0000);
      chk("both_2359_tick", {15'd0, day_tick_o}, 16'h0001);

      set_time(23, 15);
      tick(1'b0, 1'b1);
      chk("midnight_up24", t_obs, 16'h0015);
      chk("day_tick_up24", {15'd0, day_tick_o}, 16'h0001);
      tick(1'b1, 1'b0);
      chk("held_tick_clear", {15'd0, day_tick_o}, 16'h0000);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      up60_i = 1'b0;
      chk("held_up60", t_obs, 16'h0018);
      chk("pm_tied", {15'd0, pm_o}, 16'h0000);
`else
      chk("reset_12am", t_obs, 16'h1200);
      chk("reset_pm", {15'd0, pm_o}, 16'h0000);

      set_time(11, 59);
      chk("reach_1159am", t_obs, 16'h1159);
      tick(1'b1, 1'b0);
      chk("noon", t_obs, 16'h1200);
      chk("noon_pm", {15'd0, pm_o}, 16'h0001);
      chk("noon_no_tick", {15'd0, day_tick_o}, 16'h0000);
      for (int i = 0; i < 59; i++) tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      up60_i = 1'b0;
      chk("one_pm", t_obs, 16'h0100);
      chk("one_pm_flag", {15'd0, pm_o}, 16'h0001);

      set_time(23, 59);
      chk("reach_1159pm", t_obs, 16'h1159);
      tick(1'b1, 1'b0);
      chk("midnight_12h", t_obs, 16'h1200);
      chk("midnight_pm", {15'd0, pm_o}, 16'h0000);
      chk("midnight_tick", {15'd0, day_tick_o}, 16'h0001);
      tick(1'b0, 1'b0);
      chk("tick_clear_12h", {15'd0, day_tick_o}, 16'h0000);
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
